// File: rtl/pipe_pkg.sv
// Shared helpers and width constants for the register pipeline.
package pipe_pkg;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 32'sd1) ? 32'sd1 : r;
  endfunction

  localparam int DEFAULT_DEPTH = 32'sd4;
  localparam int TW = clog2_min1(DEFAULT_DEPTH);
  localparam int CW = $clog2(DEFAULT_DEPTH + 32'sd1);

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a valid bit plus WIDTH data bits with advance enable,
// synchronous flush and asynchronous reset.
module pipe_stage #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
  parameter bit               FLUSH_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // flush outranks en; with FLUSH_DATA=0 a flush only drops the valid bit
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      if (FLUSH_DATA) begin
        data_d = RESET_VAL;
      end else begin
        data_d = data_q;
      end
    end else if (en_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/reg_pipeline.sv
// DEPTH-stage valid+data delay line with flush, stall, a runtime tap and an
// occupancy counter of stages holding valid data.
module reg_pipeline
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
  parameter bit               FLUSH_DATA = 1'b1,
  localparam int              TAP_W      = clog2_min1(DEPTH),
  localparam int              CNT_W      = $clog2(DEPTH + 32'sd1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAP_W-1:0] tap_sel,
  output logic             tap_valid,
  output logic [WIDTH-1:0] tap_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic             vin_s   [DEPTH];
  logic [WIDTH-1:0] din_s   [DEPTH];
  logic             valid_s [DEPTH];
  logic [WIDTH-1:0] data_s  [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign vin_s[g] = in_valid;
      assign din_s[g] = in_data;
    end else begin : g_body
      assign vin_s[g] = valid_s[g-1];
      assign din_s[g] = data_s[g-1];
    end

    pipe_stage #(
      .WIDTH      (WIDTH),
      .RESET_VAL  (RESET_VAL),
      .FLUSH_DATA (FLUSH_DATA)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en_i    (en),
      .flush_i (flush),
      .valid_i (vin_s[g]),
      .data_i  (din_s[g]),
      .valid_o (valid_s[g]),
      .data_o  (data_s[g])
    );
  end

  logic [CNT_W-1:0] count_q, count_d;

  // occupancy follows the valid bits: one enters at stage 0, one leaves at the last stage
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = {CNT_W{1'b0}};
    end else if (en) begin
      count_d = count_q + CNT_W'(in_valid) - CNT_W'(valid_s[DEPTH-1]);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  logic             tap_valid_s;
  logic [WIDTH-1:0] tap_data_s;

  // out-of-range selects fall through to the last stage
  always_comb begin
    tap_valid_s = valid_s[DEPTH-1];
    tap_data_s  = data_s[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      tap_valid_s = (tap_sel == TAP_W'(i)) ? valid_s[i] : tap_valid_s;
      tap_data_s  = (tap_sel == TAP_W'(i)) ? data_s[i]  : tap_data_s;
    end
  end

  assign tap_valid = tap_valid_s;
  assign tap_data  = tap_data_s;
  assign out_valid = valid_s[DEPTH-1];
  assign out_data  = data_s[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_reg_pipeline.sv
// Directed bench for reg_pipeline: two 8x4 configs differing in flush behaviour,
// an 8x3 config for tap clamping and a 1x1 config for flip-flop equivalence.
module tb_reg_pipeline;

  logic       clk = 1'b0;
  logic       reset, en, flush, in_valid;
  logic [7:0] in_data;
  logic [1:0] tap_sel;
  logic       c_din;

  logic       a_tap_valid, a_out_valid, b_tap_valid, b_out_valid, d_tap_valid, d_out_valid;
  logic [7:0] a_tap_data, a_out_data, b_tap_data, b_out_data, d_tap_data, d_out_data;
  logic [2:0] a_count, b_count;
  logic [1:0] d_count;
  logic       c_tap_valid, c_tap_data, c_out_valid, c_out_data, c_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5), .FLUSH_DATA(1'b1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .tap_sel(tap_sel), .tap_valid(a_tap_valid), .tap_data(a_tap_data),
    .out_valid(a_out_valid), .out_data(a_out_data), .count(a_count));

  reg_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5), .FLUSH_DATA(1'b0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .tap_sel(tap_sel), .tap_valid(b_tap_valid), .tap_data(b_tap_data),
    .out_valid(b_out_valid), .out_data(b_out_data), .count(b_count));

  reg_pipeline #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00), .FLUSH_DATA(1'b1)) dut_d (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .tap_sel(tap_sel), .tap_valid(d_tap_valid), .tap_data(d_tap_data),
    .out_valid(d_out_valid), .out_data(d_out_data), .count(d_count));

  reg_pipeline #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0), .FLUSH_DATA(1'b1)) dut_c (
    .clk(clk), .reset(reset), .en(1'b1), .flush(1'b0), .in_valid(1'b1), .in_data(c_din),
    .tap_sel(1'b0), .tap_valid(c_tap_valid), .tap_data(c_tap_data),
    .out_valid(c_out_valid), .out_data(c_out_data), .count(c_count));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; tap_sel = 2'd0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; tap_sel = 2'd2; c_din = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    tests++; if (a_out_data !== 8'hA5) begin fails++; $display("FAIL reset_out_data: got %h expected a5", a_out_data); end
    tests++; if (a_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", a_count); end
    en = 1'b1; in_valid = 1'b1;
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33; tick();
    en = 1'b0; in_valid = 1'b0;
    tests++; if (a_count !== 3'd3) begin fails++; $display("FAIL prereset_count: got %0d expected 3", a_count); end
    tests++; if (a_tap_data !== 8'h11 || a_tap_valid !== 1'b1) begin fails++; $display("FAIL prereset_tap: got %b/%h expected 1/11", a_tap_valid, a_tap_data); end
    #2 reset = 1'b1;
    #1;
    tests++; if (a_count !== 3'd0) begin fails++; $display("FAIL midreset_count: got %0d expected 0", a_count); end
    tests++; if (a_out_valid !== 1'b0 || a_out_data !== 8'hA5) begin fails++; $display("FAIL midreset_out: got %b/%h expected 0/a5", a_out_valid, a_out_data); end
    tests++; if (a_tap_valid !== 1'b0 || a_tap_data !== 8'hA5) begin fails++; $display("FAIL midreset_tap: got %b/%h expected 0/a5", a_tap_valid, a_tap_data); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_latency();
    logic [2:0] exp_cnt [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    do_reset();
    en = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      in_data = 8'(k);
      tick();
      tests++; if (a_count !== exp_cnt[k-1]) begin fails++; $display("FAIL latency_count[%0d]: got %0d expected %0d", k, a_count, exp_cnt[k-1]); end
      if (k >= 4) begin
        tests++; if (a_out_valid !== 1'b1 || a_out_data !== 8'(k-3)) begin fails++; $display("FAIL latency_out[%0d]: got %b/%h expected 1/%h", k, a_out_valid, a_out_data, 8'(k-3)); end
      end else begin
        tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL latency_early[%0d]: got %b expected 0", k, a_out_valid); end
      end
    end
    en = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic       exp_v [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_d [4] = '{8'hA5, 8'hAA, 8'hBB, 8'h00};
    logic [2:0] exp_c [4] = '{3'd2, 3'd2, 3'd1, 3'd0};
    do_reset();
    en = 1'b1; in_valid = 1'b1;
    in_data = 8'hAA; tick();
    in_data = 8'hBB; tick();
    en = 1'b0; in_valid = 1'b0; in_data = 8'h00; tap_sel = 2'd1;
    for (int s = 0; s < 3; s++) begin
      tick();
      tests++; if (a_count !== 3'd2 || a_out_valid !== 1'b0 || a_tap_data !== 8'hAA || a_tap_valid !== 1'b1) begin
        fails++; $display("FAIL stall_hold[%0d]: got cnt=%0d ov=%b tap=%b/%h expected 2/0/1/aa", s, a_count, a_out_valid, a_tap_valid, a_tap_data); end
    end
    en = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      tests++; if (a_out_valid !== exp_v[e] || a_out_data !== exp_d[e] || a_count !== exp_c[e]) begin
        fails++; $display("FAIL stall_release[%0d]: got %b/%h cnt=%0d expected %b/%h cnt=%0d", e, a_out_valid, a_out_data, a_count, exp_v[e], exp_d[e], exp_c[e]); end
    end
    en = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    en = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_data = 8'(k);
      tick();
    end
    tests++; if (a_count !== 3'd4 || a_out_data !== 8'h01) begin fails++; $display("FAIL preflush: got cnt=%0d out=%h expected 4/01", a_count, a_out_data); end
    flush = 1'b1; in_data = 8'hFF;
    tick();
    flush = 1'b0; en = 1'b0; in_valid = 1'b0;
    tests++; if (a_count !== 3'd0 || b_count !== 3'd0) begin fails++; $display("FAIL flush_count: got a=%0d b=%0d expected 0/0", a_count, b_count); end
    tests++; if (a_out_valid !== 1'b0 || a_out_data !== 8'hA5) begin fails++; $display("FAIL flush_data1_out: got %b/%h expected 0/a5", a_out_valid, a_out_data); end
    tests++; if (b_out_valid !== 1'b0 || b_out_data !== 8'h01) begin fails++; $display("FAIL flush_data0_out: got %b/%h expected 0/01", b_out_valid, b_out_data); end
    for (int t = 0; t < 4; t++) begin
      tap_sel = 2'(t);
      #1;
      tests++; if (a_tap_valid !== 1'b0 || b_tap_valid !== 1'b0) begin fails++; $display("FAIL flush_valid[%0d]: got a=%b b=%b expected 0/0", t, a_tap_valid, b_tap_valid); end
    end
    tap_sel = 2'd0;
    #1;
    tests++; if (b_tap_data !== 8'h04) begin fails++; $display("FAIL flush_data0_stage0: got %h expected 04", b_tap_data); end
  endtask

  task automatic test_bubble_tap();
    logic       iv  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] dat [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00};
    logic       etv [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] etd [5] = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40};
    logic [2:0] ec  [5] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd1};
    logic [2:0] peak;
    do_reset();
    peak = 3'd0;
    tap_sel = 2'd1; en = 1'b1;
    for (int e = 0; e < 5; e++) begin
      in_valid = iv[e]; in_data = dat[e];
      tick();
      if (a_count > peak) peak = a_count;
      tests++; if (a_tap_valid !== etv[e] || a_tap_data !== etd[e] || a_count !== ec[e]) begin
        fails++; $display("FAIL bubble[%0d]: got tap=%b/%h cnt=%0d expected %b/%h cnt=%0d", e, a_tap_valid, a_tap_data, a_count, etv[e], etd[e], ec[e]); end
    end
    en = 1'b0; in_valid = 1'b0;
    tests++; if (peak !== 3'd2) begin fails++; $display("FAIL bubble_peak: got %0d expected 2", peak); end
    tests++; if (d_count !== 2'd1 || d_out_valid !== 1'b1 || d_out_data !== 8'h30) begin fails++; $display("FAIL depth3_out: got %0d %b/%h expected 1 1/30", d_count, d_out_valid, d_out_data); end
    tap_sel = 2'd3;
    #1;
    tests++; if (a_tap_valid !== 1'b0 || a_tap_data !== 8'h20) begin fails++; $display("FAIL tap_last: got %b/%h expected 0/20", a_tap_valid, a_tap_data); end
    tests++; if (d_tap_valid !== 1'b1 || d_tap_data !== 8'h30) begin fails++; $display("FAIL tap_clamp: got %b/%h expected 1/30", d_tap_valid, d_tap_data); end
  endtask

  task automatic test_dff();
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic prev;
    do_reset();
    prev = 1'b0;
    for (int e = 0; e < 5; e++) begin
      c_din = pat[e];
      #1;
      tests++; if (c_out_data !== prev) begin fails++; $display("FAIL dff_hold[%0d]: got %b expected %b", e, c_out_data, prev); end
      tick();
      tests++; if (c_out_data !== pat[e] || c_out_valid !== 1'b1 || c_tap_data !== pat[e]) begin
        fails++; $display("FAIL dff_q[%0d]: got %b/%b tap=%b expected 1/%b", e, c_out_valid, c_out_data, c_tap_data, pat[e]); end
      prev = pat[e];
    end
    tests++; if (c_count !== 1'b1 || c_tap_valid !== 1'b1) begin fails++; $display("FAIL dff_count: got %b tv=%b expected 1/1", c_count, c_tap_valid); end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tap_sel = 2'd0; c_din = 1'b0;
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_bubble_tap();
    test_dff();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
